// File: rtl/step_pos_tracker.sv
// Absolute step-position tracker for the slide table. It counts step edges by direction,
// zeroes on a debounced home switch or a software request, and flags motion and fault status.
module step_pos_tracker #(
    parameter int POS_W     = 32,
    parameter int DEB_LEN   = 16,
    parameter int IDLE_CYC  = 1000,
    parameter int DIR_SETUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             home_sw,
    input  logic             zero,
    input  logic [POS_W-1:0] target,
    output logic [POS_W-1:0] pos,
    output logic             at_target,
    output logic             moving,
    output logic             homed,
    output logic             home_hit,
    output logic             dir_err,
    output logic             limit_err
);

    localparam int DEB_W  = $clog2(DEB_LEN + 1);
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int DIR_W  = $clog2(DIR_SETUP + 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } deb_state_t;

    logic [1:0]       sync_reg;
    deb_state_t       state_reg;
    deb_state_t       state_next;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic [DEB_W-1:0] deb_cnt_next;
    logic             home_event;
    logic             sw_pressed;
    logic             sample_differs;

    logic             step_prev_reg;
    logic             step_edge;
    logic             dir_prev_reg;
    logic [DIR_W-1:0] dir_stab_reg;
    logic             dir_changed;
    logic             dir_unstable;

    logic [POS_W-1:0]  pos_reg;
    logic              at_target_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;
    logic              homed_reg;
    logic              home_hit_reg;
    logic              dir_err_reg;
    logic              limit_err_reg;

    // The switch idles high (released), so the synchronizer resets to 1 to avoid a false press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], home_sw};
        end
    end

    assign sw_pressed     = ~sync_reg[1];
    assign sample_differs = (state_reg == RELEASED) ? sw_pressed : ~sw_pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RELEASED;
            deb_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            deb_cnt_reg <= deb_cnt_next;
        end
    end

    // A full run of DEB_LEN disagreeing samples toggles the state on the following edge.
    always_comb begin
        state_next   = state_reg;
        deb_cnt_next = '0;
        if (deb_cnt_reg == DEB_W'(DEB_LEN)) begin
            state_next   = (state_reg == RELEASED) ? PRESSED : RELEASED;
            deb_cnt_next = '0;
        end else if (sample_differs) begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
    end

    always_comb begin
        home_event = 1'b0;
        if (state_reg == RELEASED && deb_cnt_reg == DEB_W'(DEB_LEN)) begin
            home_event = 1'b1;
        end
    end

    assign step_edge    = step_in & ~step_prev_reg;
    assign dir_changed  = (dir_in != dir_prev_reg);
    assign dir_unstable = dir_changed || (dir_stab_reg < DIR_W'(DIR_SETUP));

    // Previous-step register resets high so a step line held high through reset is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_prev_reg <= 1'b1;
            dir_prev_reg  <= 1'b0;
            dir_stab_reg  <= '0;
        end else begin
            step_prev_reg <= step_in;
            dir_prev_reg  <= dir_in;
            if (dir_changed) begin
                dir_stab_reg <= '0;
            end else if (dir_stab_reg < DIR_W'(DIR_SETUP)) begin
                dir_stab_reg <= dir_stab_reg + DIR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_reg       <= '0;
            at_target_reg <= 1'b0;
            idle_cnt_reg  <= '0;
            homed_reg     <= 1'b0;
            home_hit_reg  <= 1'b0;
            dir_err_reg   <= 1'b0;
            limit_err_reg <= 1'b0;
        end else begin
            at_target_reg <= (pos_reg == target);
            home_hit_reg  <= home_event;
            if (home_event) begin
                homed_reg <= 1'b1;
            end

            // Home event beats zero, which beats a step; a coinciding step is dropped.
            if (home_event || zero) begin
                pos_reg <= '0;
            end else if (step_edge) begin
                if (!dir_in) begin
                    pos_reg <= pos_reg + POS_W'(1);
                end else if (state_reg == PRESSED) begin
                    limit_err_reg <= 1'b1;
                end else begin
                    pos_reg <= pos_reg - POS_W'(1);
                end
            end

            if (step_edge && dir_unstable) begin
                dir_err_reg <= 1'b1;
            end

            if (step_edge) begin
                idle_cnt_reg <= IDLE_W'(IDLE_CYC);
            end else if (idle_cnt_reg != '0) begin
                idle_cnt_reg <= idle_cnt_reg - IDLE_W'(1);
            end
        end
    end

    assign pos       = pos_reg;
    assign at_target = at_target_reg;
    assign moving    = (idle_cnt_reg != '0);
    assign homed     = homed_reg;
    assign home_hit  = home_hit_reg;
    assign dir_err   = dir_err_reg;
    assign limit_err = limit_err_reg;

endmodule

// File: tb/tb_step_pos_tracker.sv
// Scenario bench for step_pos_tracker: a position model feeds a scoreboard queue that is
// popped after each DUT update, plus inline status-flag checks per scenario.
module tb_step_pos_tracker;

    localparam int POS_W     = 32;
    localparam int DEB_LEN   = 16;
    localparam int IDLE_CYC  = 1000;
    localparam int DIR_SETUP = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             step_in;
    logic             dir_in;
    logic             home_sw;
    logic             zero;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] pos;
    logic             at_target;
    logic             moving;
    logic             homed;
    logic             home_hit;
    logic             dir_err;
    logic             limit_err;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    logic [POS_W-1:0] exp_pos;
    logic [POS_W-1:0] exp_q[$];
    bit               pressed_model;

    step_pos_tracker #(
        .POS_W(POS_W),
        .DEB_LEN(DEB_LEN),
        .IDLE_CYC(IDLE_CYC),
        .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step_in(step_in),
        .dir_in(dir_in),
        .home_sw(home_sw),
        .zero(zero),
        .target(target),
        .pos(pos),
        .at_target(at_target),
        .moving(moving),
        .homed(homed),
        .home_hit(home_hit),
        .dir_err(dir_err),
        .limit_err(limit_err)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dir(input logic d);
        dir_in = d;
        repeat (DIR_SETUP + 2) tick();
    endtask

    // One step pulse with the current direction; the model pushes the expectation first.
    task automatic do_step();
        logic [POS_W-1:0] want;
        if (dir_in) begin
            if (!pressed_model) exp_pos = exp_pos - 1;
        end else begin
            exp_pos = exp_pos + 1;
        end
        exp_q.push_back(exp_pos);
        step_in = 1'b1;
        tick();
        want = exp_q.pop_front();
        checks++;
        step_no++;
        if (pos !== want) begin
            failures++;
            $display("FAIL step_pos: step %0d dir=%0d pos=%h want %h", step_no, dir_in, pos, want);
        end else begin
            $display("step %0d dir=%0d pos=%h", step_no, dir_in, pos);
        end
        step_in = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_pos = '0;
        pressed_model = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        step_in = 1'b1;
        dir_in  = 1'b0;
        home_sw = 1'b1;
        zero    = 1'b0;
        target  = '0;
        do_reset();
        checks++;
        if ({pos, at_target, moving, homed, home_hit, dir_err, limit_err} !== {POS_W'(0), 6'b0}) begin
            failures++;
            $display("FAIL reset_state: pos=%h flags=%b want 0 / 000000", pos,
                     {at_target, moving, homed, home_hit, dir_err, limit_err});
        end
        repeat (3) tick();
        exp_q.push_back(exp_pos);
        checks++;
        if (pos !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL reset_held_step: pos=%h want 0", pos);
        end
        checks++;
        if (at_target !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_compare: at_target=%b want 1", at_target);
        end
        step_in = 1'b0;
        repeat (DIR_SETUP + 2) tick();
        $display("reset: pos=%h at_target=%b", pos, at_target);
    endtask

    task automatic test_count();
        target = POS_W'(180);
        for (int i = 0; i < 300; i++) do_step();
        set_dir(1'b1);
        for (int i = 0; i < 120; i++) do_step();
        checks++;
        if (at_target !== 1'b1) begin
            failures++;
            $display("FAIL count_at_target: at_target=%b want 1 (pos=%h)", at_target, pos);
        end
        // A level held high for several cycles is one step.
        set_dir(1'b0);
        step_in = 1'b1;
        repeat (5) tick();
        step_in = 1'b0;
        tick();
        exp_pos = exp_pos + 1;
        exp_q.push_back(exp_pos);
        checks++;
        if (pos !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL held_step: pos=%h want %h", pos, exp_pos);
        end
        checks++;
        if (at_target !== 1'b0) begin
            failures++;
            $display("FAIL count_off_target: at_target=%b want 0", at_target);
        end
        $display("count: pos=%h at_target=%b", pos, at_target);
    endtask

    task automatic test_wrap();
        zero = 1'b1;
        tick();
        zero = 1'b0;
        exp_pos = '0;
        exp_q.push_back(exp_pos);
        checks++;
        if (pos !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL zero_req: pos=%h want 0", pos);
        end
        set_dir(1'b1);
        do_step();
        set_dir(1'b0);
        do_step();
        $display("wrap: pos=%h", pos);
    endtask

    task automatic test_home();
        bit early_hit = 1'b0;
        for (int i = 0; i < 500; i++) do_step();
        home_sw = 1'b0;
        for (int i = 0; i < DEB_LEN + 2; i++) begin
            tick();
            if (home_hit) early_hit = 1'b1;
        end
        checks++;
        if (early_hit) begin
            failures++;
            $display("FAIL home_early: home_hit=1 before edge k+%0d want 0", DEB_LEN + 2);
        end
        tick();
        exp_pos = '0;
        pressed_model = 1'b1;
        exp_q.push_back(exp_pos);
        checks++;
        if (home_hit !== 1'b1 || homed !== 1'b1) begin
            failures++;
            $display("FAIL home_event: home_hit=%b homed=%b want 1 1", home_hit, homed);
        end
        checks++;
        if (pos !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL home_pos: pos=%h want 0", pos);
        end
        tick();
        checks++;
        if (home_hit !== 1'b0) begin
            failures++;
            $display("FAIL home_pulse_width: home_hit=%b want 0", home_hit);
        end
        $display("home: pos=%h homed=%b", pos, homed);
    endtask

    task automatic test_limit();
        set_dir(1'b1);
        for (int i = 0; i < 3; i++) do_step();
        checks++;
        if (limit_err !== 1'b1) begin
            failures++;
            $display("FAIL limit_err: limit_err=%b want 1", limit_err);
        end
        set_dir(1'b0);
        for (int i = 0; i < 3; i++) do_step();
        $display("limit: pos=%h limit_err=%b", pos, limit_err);
    endtask

    task automatic test_glitch();
        bit any_hit = 1'b0;
        home_sw = 1'b1;
        for (int i = 0; i < DEB_LEN + 6; i++) begin
            tick();
            if (home_hit) any_hit = 1'b1;
        end
        pressed_model = 1'b0;
        home_sw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (home_hit) any_hit = 1'b1;
        end
        home_sw = 1'b1;
        for (int i = 0; i < DEB_LEN + 8; i++) begin
            tick();
            if (home_hit) any_hit = 1'b1;
        end
        checks++;
        if (any_hit) begin
            failures++;
            $display("FAIL glitch_event: home_hit seen=1 want 0");
        end
        // Released again, so a toward-home step must decrement.
        set_dir(1'b1);
        do_step();
        $display("glitch: pos=%h", pos);
    endtask

    task automatic test_dir_err();
        checks++;
        if (dir_err !== 1'b0 || limit_err !== 1'b1) begin
            failures++;
            $display("FAIL flags_before_dir: dir_err=%b limit_err=%b want 0 1", dir_err, limit_err);
        end
        dir_in = 1'b0;
        tick();
        tick();
        step_in = 1'b1;
        tick();
        exp_pos = exp_pos + 1;
        exp_q.push_back(exp_pos);
        checks++;
        if (pos !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL dir_err_step: pos=%h want %h", pos, exp_pos);
        end
        checks++;
        if (dir_err !== 1'b1) begin
            failures++;
            $display("FAIL dir_err_set: dir_err=%b want 1", dir_err);
        end
        step_in = 1'b0;
        tick();
        do_reset();
        checks++;
        if ({dir_err, limit_err, homed} !== 3'b000 || pos !== POS_W'(0)) begin
            failures++;
            $display("FAIL rst_clear: dir_err=%b limit_err=%b homed=%b pos=%h want 0 0 0 0",
                     dir_err, limit_err, homed, pos);
        end
        $display("dir_err: cleared by reset, dir_err=%b", dir_err);
    endtask

    task automatic test_collide();
        repeat (DIR_SETUP + 2) tick();
        do_step();
        do_step();
        step_in = 1'b1;
        zero    = 1'b1;
        tick();
        exp_pos = '0;
        exp_q.push_back(exp_pos);
        checks++;
        if (pos !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL zero_collide: pos=%h want 0", pos);
        end
        zero    = 1'b0;
        step_in = 1'b0;
        tick();
        do_step();
        do_step();
        home_sw = 1'b0;
        repeat (DEB_LEN + 2) tick();
        step_in = 1'b1;
        tick();
        exp_pos = '0;
        pressed_model = 1'b1;
        exp_q.push_back(exp_pos);
        checks++;
        if (pos !== exp_q.pop_front() || home_hit !== 1'b1) begin
            failures++;
            $display("FAIL home_collide: pos=%h home_hit=%b want 0 1", pos, home_hit);
        end
        step_in = 1'b0;
        tick();
        $display("collide: pos=%h", pos);
    endtask

    task automatic test_moving();
        int n = 0;
        do_step();
        while (moving && n < IDLE_CYC + 100) begin
            tick();
            n++;
        end
        // do_step returns one edge after the detecting edge, so n+1 edges have elapsed.
        checks++;
        if (n + 1 !== IDLE_CYC) begin
            failures++;
            $display("FAIL moving_idle: moving fell after %0d cycles want %0d", n + 1, IDLE_CYC);
        end
        $display("moving: fell after %0d cycles", n + 1);
    endtask

    initial begin
        rst           = 1'b1;
        step_in       = 1'b0;
        dir_in        = 1'b0;
        home_sw       = 1'b1;
        zero          = 1'b0;
        target        = '0;
        exp_pos       = '0;
        pressed_model = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_home();
        test_limit();
        test_glitch();
        test_dir_err();
        test_collide();
        test_moving();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
